// File: rtl/level_sequencer.sv
// level_sequencer: frame-rate game-flow controller feeding the colour mapper.
// Tracks lives, advances levels, holds timed HIT/ADVANCE screens and flags
// win / game-over. Optional background fade: define LEVEL_SEQ_FADE_EN.
module level_sequencer #(
   parameter int unsigned NUM_LEVELS  = 3,
   parameter int unsigned LIVES_INIT  = 3,
   parameter int unsigned HOLD_FRAMES = 60
) (
   input  logic       frame_clk,
   input  logic       reset,
   input  logic       start,
   input  logic       finish_line_reached,
   input  logic       collision,
   input  logic       collision2,
   output logic [1:0] current_level,
   output logic [3:0] background,
   output logic       reset_player,
   output logic [2:0] lives,
   output logic       game_over,
   output logic       game_won
);

   localparam logic [1:0] LAST_LEVEL = 2'(NUM_LEVELS - 1);
   localparam logic [2:0] LIVES_RST  = 3'(LIVES_INIT);
   localparam logic [7:0] HOLD_LOAD  = 8'(HOLD_FRAMES - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAY,
      S_HIT,
      S_ADVANCE,
      S_WON,
      S_LOST
   } state_t;

   state_t     state_q, state_d;
   logic [1:0] level_q, level_d;
   logic [2:0] lives_q, lives_d;
   logic [7:0] hold_q, hold_d;
   logic [3:0] bg_q, bg_d;
   logic       reset_player_q, reset_player_d;
   logic       game_over_q, game_over_d;
   logic       game_won_q, game_won_d;
   logic       hit;

   assign hit = collision | collision2;

   // Background intensity associated with each level.
   function automatic logic [3:0] level_bg(input logic [1:0] lvl);
      case (lvl)
         2'd0:    level_bg = 4'h8;
         2'd1:    level_bg = 4'hA;
         2'd2:    level_bg = 4'hC;
         default: level_bg = 4'hE;
      endcase
   endfunction

   // Next-state, level, lives and hold-counter decode; flag outputs follow the next state.
   always_comb begin
      state_d = state_q;
      level_d = level_q;
      lives_d = lives_q;
      hold_d  = hold_q;
      case (state_q)
         S_IDLE, S_WON, S_LOST: begin
            if (start) begin
               state_d = S_PLAY;
               level_d = '0;
               lives_d = LIVES_RST;
            end
         end
         S_PLAY: begin
            if (finish_line_reached) begin
               if (level_q == LAST_LEVEL) begin
                  state_d = S_WON;
               end else begin
                  state_d = S_ADVANCE;
                  hold_d  = HOLD_LOAD;
               end
            end else if (hit) begin
               if (lives_q > 3'd1) begin
                  lives_d = lives_q - 3'd1;
                  hold_d  = HOLD_LOAD;
                  state_d = S_HIT;
               end else begin
                  lives_d = '0;
                  state_d = S_LOST;
               end
            end
         end
         S_HIT: begin
            if (hold_q == '0) state_d = S_PLAY;
            else              hold_d  = hold_q - 8'd1;
         end
         S_ADVANCE: begin
            if (hold_q == '0) begin
               state_d = S_PLAY;
               level_d = level_q + 2'd1;
            end else begin
               hold_d = hold_q - 8'd1;
            end
         end
         default: state_d = S_IDLE;
      endcase
      reset_player_d = (state_d != S_PLAY);
      game_over_d    = (state_d == S_LOST);
      game_won_d     = (state_d == S_WON);
   end

`ifdef LEVEL_SEQ_FADE_EN
   logic [3:0] target_q, target_d;

   // Fade target follows state entries; background ramps one step per frame toward it.
   always_comb begin
      target_d = target_q;
      if (state_d != state_q) begin
         if (state_d == S_ADVANCE || state_d == S_LOST) target_d = '0;
         else if (state_d == S_PLAY)                    target_d = level_bg(level_d);
      end
      if (bg_q < target_d)      bg_d = bg_q + 4'd1;
      else if (bg_q > target_d) bg_d = bg_q - 4'd1;
      else                      bg_d = bg_q;
   end

   // Fade target register.
   always_ff @(posedge frame_clk or posedge reset) begin
      if (reset) target_q <= '0;
      else       target_q <= target_d;
   end

   localparam logic [3:0] BG_RST = 4'h0;
`else
   // Background tracks the level table in the same edge as the level update.
   always_comb begin
      bg_d = level_bg(level_d);
   end

   localparam logic [3:0] BG_RST = 4'h8;
`endif

   // State and registered-output update.
   always_ff @(posedge frame_clk or posedge reset) begin
      if (reset) begin
         state_q        <= S_IDLE;
         level_q        <= '0;
         lives_q        <= LIVES_RST;
         hold_q         <= '0;
         bg_q           <= BG_RST;
         reset_player_q <= 1'b1;
         game_over_q    <= 1'b0;
         game_won_q     <= 1'b0;
      end else begin
         state_q        <= state_d;
         level_q        <= level_d;
         lives_q        <= lives_d;
         hold_q         <= hold_d;
         bg_q           <= bg_d;
         reset_player_q <= reset_player_d;
         game_over_q    <= game_over_d;
         game_won_q     <= game_won_d;
      end
   end

   assign current_level = level_q;
   assign background    = bg_q;
   assign reset_player  = reset_player_q;
   assign lives         = lives_q;
   assign game_over     = game_over_q;
   assign game_won      = game_won_q;

endmodule

// File: tb/tb_level_sequencer.sv
// tb_level_sequencer: scoreboard bench for level_sequencer (default build).
module tb_level_sequencer;

   localparam int TB_LEVELS = 3;
   localparam int TB_LIVES  = 3;
   localparam int TB_HOLD   = 60;

   logic       frame_clk = 1'b0;
   logic       reset;
   logic       start;
   logic       finish_line_reached;
   logic       collision;
   logic       collision2;
   logic [1:0] current_level;
   logic [3:0] background;
   logic       reset_player;
   logic [2:0] lives;
   logic       game_over;
   logic       game_won;

   level_sequencer #(
      .NUM_LEVELS (TB_LEVELS),
      .LIVES_INIT (TB_LIVES),
      .HOLD_FRAMES(TB_HOLD)
   ) dut (
      .frame_clk          (frame_clk),
      .reset              (reset),
      .start              (start),
      .finish_line_reached(finish_line_reached),
      .collision          (collision),
      .collision2         (collision2),
      .current_level      (current_level),
      .background         (background),
      .reset_player       (reset_player),
      .lives              (lives),
      .game_over          (game_over),
      .game_won           (game_won)
   );

   always #5 frame_clk = ~frame_clk;

   typedef enum int {M_IDLE, M_PLAY, M_HIT, M_ADV, M_WON, M_LOST} mstate_t;

   typedef struct packed {
      logic [1:0] level;
      logic [2:0] lives;
      logic       rp;
      logic       go;
      logic       gw;
      logic [3:0] bg;
   } exp_t;

   exp_t    sb[$];
   mstate_t m_st;
   int      m_level;
   int      m_lives;
   int      m_hold;
   int      checks   = 0;
   int      failures = 0;

   task automatic chk(input string tag, input int got, input int expv);
      checks++;
      if (got != expv) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, expv);
      end
   endtask

   function automatic exp_t model_out();
      exp_t e;
      e.level = 2'(m_level);
      e.lives = 3'(m_lives);
      e.rp    = (m_st != M_PLAY);
      e.go    = (m_st == M_LOST);
      e.gw    = (m_st == M_WON);
      e.bg    = 4'(8 + 2 * m_level);
      return e;
   endfunction

   task automatic model_edge(input logic s, input logic f, input logic h);
      case (m_st)
         M_IDLE, M_WON, M_LOST:
            if (s) begin m_st = M_PLAY; m_level = 0; m_lives = TB_LIVES; end
         M_PLAY:
            if (f) begin
               if (m_level == TB_LEVELS - 1) m_st = M_WON;
               else begin m_st = M_ADV; m_hold = TB_HOLD - 1; end
            end else if (h) begin
               if (m_lives > 1) begin m_lives--; m_hold = TB_HOLD - 1; m_st = M_HIT; end
               else begin m_lives = 0; m_st = M_LOST; end
            end
         M_HIT:
            if (m_hold == 0) m_st = M_PLAY; else m_hold--;
         default:
            if (m_hold == 0) begin m_st = M_PLAY; m_level++; end else m_hold--;
      endcase
   endtask

   task automatic compare();
      exp_t e;
      if (sb.size() == 0) begin
         chk("sb_empty", 1, 0);
      end else begin
         e = sb.pop_front();
         chk("level", current_level, e.level);
         chk("lives", lives, e.lives);
         chk("reset_player", reset_player, e.rp);
         chk("game_over", game_over, e.go);
         chk("game_won", game_won, e.gw);
`ifndef LEVEL_SEQ_FADE_EN
         chk("background", background, e.bg);
`endif
      end
   endtask

   // One frame: drive inputs, predict, clock, compare away from the edge.
   task automatic step(input logic s, input logic f, input logic c1, input logic c2);
      start = s; finish_line_reached = f; collision = c1; collision2 = c2;
      model_edge(s, f, c1 | c2);
      sb.push_back(model_out());
      @(posedge frame_clk);
      #1;
      compare();
   endtask

   task automatic model_reset();
      m_st = M_IDLE; m_level = 0; m_lives = TB_LIVES; m_hold = 0;
   endtask

   // Assert reset mid-frame and check outputs before any clock edge.
   task automatic mid_reset();
      #3;
      reset = 1'b1;
      #1;
      model_reset();
      sb.push_back(model_out());
      compare();
      chk("rst_level", current_level, 0);
      chk("rst_lives", lives, 3);
      chk("rst_rp", reset_player, 1);
      @(posedge frame_clk);
      #1;
      reset = 1'b0;
   endtask

   // Run a transition hold, poking ignored inputs, and check its length.
   task automatic wait_hold(input string tag);
      int n = 0;
      while (reset_player && n < 200) begin
         step(n == 9, n == 5, n == 7, n == 11);
         n++;
      end
      chk(tag, n, TB_HOLD);
   endtask

   initial begin
      reset = 1'b1; start = 1'b0; finish_line_reached = 1'b0;
      collision = 1'b0; collision2 = 1'b0;
      model_reset();
      #2;
      sb.push_back(model_out());
      compare();
      @(posedge frame_clk);
      #1;
      reset = 1'b0;

      step(0, 0, 0, 0);
      step(0, 1, 1, 0);
      chk("idle_rp", reset_player, 1);

      step(1, 0, 0, 0);
      chk("start_rp", reset_player, 0);
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      wait_hold("adv0_len");
      chk("adv0_level", current_level, 1);
      chk("adv0_rp", reset_player, 0);

      step(0, 1, 0, 1);
      chk("goal_beats_hit_lives", lives, 3);
      wait_hold("adv1_len");
      chk("adv1_level", current_level, 2);

      step(0, 0, 1, 0);
      chk("hit1_lives", lives, 2);
      wait_hold("hit1_len");
      step(0, 0, 0, 1);
      chk("hit2_lives", lives, 1);
      wait_hold("hit2_len");
      step(0, 0, 1, 1);
      chk("hit3_lives", lives, 0);
      chk("hit3_over", game_over, 1);
      step(0, 1, 1, 0);
      chk("lost_hold", game_over, 1);

      step(1, 0, 0, 0);
      chk("restart_lives", lives, 3);
      chk("restart_level", current_level, 0);
      step(0, 0, 0, 0);

      step(0, 1, 0, 0);
      wait_hold("win_adv0");
      step(0, 1, 0, 0);
      wait_hold("win_adv1");
      step(0, 1, 0, 0);
      chk("won_flag", game_won, 1);
      chk("won_no_adv_level", current_level, 2);
      step(0, 0, 1, 0);
      chk("won_ignore_hit", game_won, 1);
      chk("won_ignore_lives", lives, 3);
      step(1, 0, 0, 0);
      chk("won_restart", game_won, 0);

      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      repeat (10) step(0, 0, 0, 0);
      mid_reset();
      repeat (3) step(0, 0, 0, 0);
      chk("post_rst_rp", reset_player, 1);
      chk("post_rst_level", current_level, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

endmodule

// File: doc/level_sequencer.md
# level_sequencer

Frame-rate game-flow controller that sits directly upstream of the colour mapper. It consumes the mapper's `finish_line_reached`, `collision` and `collision2` flags. It drives the mapper's `current_level` and `background` inputs and the player-respawn request. The block tracks lives, advances levels, holds timed transition screens, and reports win and game-over.

## Interface
- `NUM_LEVELS`, 3: number of playable levels, 1–4; `current_level` runs 0..`NUM_LEVELS`-1.
- `LIVES_INIT`, 3: lives loaded at reset and at restart, 1–7.
- `HOLD_FRAMES`, 60: frames spent in each transition state (`HIT`, `ADVANCE`), 2–255.
- `frame_clk`  in  1  frame-rate clock; one edge per video frame.
- `reset`  in  1  asynchronous, active-high.
- `start`  in  1  level-sensitive start/restart request (decoded keypress).
- `finish_line_reached`  in  1  player reached the goal this frame.
- `collision`  in  1  player touched obstacle 1.
- `collision2`  in  1  player touched obstacle 2.
- `current_level`  out  2  active level index.
- `background`  out  4  background intensity for the mapper.
- `reset_player`  out  1  holds the player at the spawn point while high.
- `lives`  out  3  remaining lives.
- `game_over`  out  1  high in `LOST`.
- `game_won`  out  1  high in `WON`.

## Operation
- States:
  - `IDLE`: waiting for `start`.
  - `PLAY`: level in progress.
  - `HIT`: respawn after a collision.
  - `ADVANCE`: level-complete pause.
  - `WON`: all levels cleared.
  - `LOST`: no lives left.
- `hit` = `collision | collision2`.
- `IDLE`:
  - `reset_player`=1.
  - `start`=1 → `PLAY`, with `current_level`=0 and `lives`=`LIVES_INIT`.
- `PLAY`:
  - `reset_player`=0.
  - `finish_line_reached`=1 has priority over `hit` in the same frame.
  - Goal on the last level → `WON`; otherwise → `ADVANCE`, with the hold counter loaded to `HOLD_FRAMES`-1.
  - `hit`=1 and `lives`>1 → decrement `lives`, load the hold counter, go to `HIT`.
  - `hit`=1 and `lives`==1 → `lives`=0, go to `LOST`.
- `HIT`:
  - `reset_player`=1.
  - The counter decrements each frame. At 0 → `PLAY`.
  - `hit`, `finish_line_reached` and `start` are ignored.
- `ADVANCE`:
  - `reset_player`=1.
  - At counter 0: `current_level` increments and the state goes to `PLAY`.
  - `lives` is unchanged.
- `WON` / `LOST`:
  - `reset_player`=1; all inputs are ignored except `start`.
  - `start` → `PLAY`, with `current_level`=0 and `lives`=`LIVES_INIT`.
  - The restart is level-sensitive. `start` must be released and pressed again only from `IDLE`; holding it through `WON` is treated as a restart.
- `background` (fade compiled out): level 0→4'h8, 1→4'hA, 2→4'hC, 3→4'hE. It is driven from the registered `current_level`.
- Hold counter is 8 bits. It never wraps: it stops at 0, and the state exit fires on the frame it reads 0.

## Timing
- All outputs are registered. They update on the `frame_clk` edge that samples the causing input: one frame of latency from a flag to its response.
- `reset` asserted, asynchronously:
  - state=`IDLE`, `current_level`=0, `lives`=`LIVES_INIT`.
  - `background`=4'h8, or 4'h0 with fade compiled in.
  - `reset_player`=1, `game_over`=0, `game_won`=0, hold counter=0.
- Reset mid-transition abandons the hold immediately; no residual pulse.
- `HIT` and `ADVANCE` last exactly `HOLD_FRAMES` frames each, entry edge to exit edge.
- `reset_player` stays high for the whole of `HIT`/`ADVANCE` and drops on the edge that enters `PLAY`.

## Configuration
- `LEVEL_SEQ_FADE_EN` defined:
  - Registered 4-bit `background` ramps toward the level target by 1 per frame.
  - On entering `ADVANCE` or `LOST`, the target becomes 4'h0, so the screen fades out.
  - On entering `PLAY`, the target becomes the new level value.
  - The ramp saturates at the target and never overshoots or wraps.
- `LEVEL_SEQ_FADE_EN` undefined: `background` jumps to the level table value in the same edge as the `current_level` update; no ramp logic is present.

## Test plan
- **Reset:**
  - Stimulus: assert `reset` mid-frame.
  - Required: outputs take reset values without a clock edge.
  - Required: `current_level`=0, `lives`=3, `reset_player`=1.
- **Start and advance:**
  - Stimulus: `start` pulse, then `finish_line_reached` one frame.
  - Required: `ADVANCE` lasts 60 frames, then `current_level`=1 and `reset_player`=0.
- **Goal beats collision:**
  - Stimulus: `finish_line_reached` and `collision2` high in the same `PLAY` frame.
  - Required: level advances; `lives` stays 3.
- **Lives exhaust:**
  - Stimulus: three separate collisions in `PLAY`.
  - Required: `lives` goes 2, 1, 0; `game_over`=1 after the third.
  - Required: `start` then gives `lives`=3, `current_level`=0.
- **Win:**
  - Stimulus: clear levels 0, 1, 2.
  - Required: `game_won`=1, with no `ADVANCE` after level 2.
  - Required: `collision` ignored while in `WON`.
- **Fade, with `LEVEL_SEQ_FADE_EN`:**
  - Stimulus: enter `ADVANCE` from level 0.
  - Required: `background` goes 8→0 in 8 frames and holds 0.
  - Required: after the transition it ramps 0→A in 10 frames.
